// File: rtl/cpu_mem_bridge.sv
// rtl/cpu_mem_bridge.sv - CPU instruction/data channel arbiter onto one single-port word SRAM
// Data requests win over instruction fetches; read data returns through registered valid/ready.
module cpu_mem_bridge #(
   parameter int ADDR_W = 14,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       PC,
   input  logic              Inst_Req_Valid,
   output logic              Inst_Req_Ready,
   output logic [31:0]       Instruction,
   output logic              Inst_Valid,
   input  logic              Inst_Ready,
   input  logic [31:0]       Address,
   input  logic              MemWrite,
   input  logic [31:0]       Write_data,
   input  logic [3:0]        Write_strb,
   input  logic              MemRead,
   output logic              Mem_Req_Ready,
   output logic [31:0]       Read_data,
   output logic              Read_data_Valid,
   input  logic              Read_data_Ready,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP_I, RESP_D} state_t;

   localparam logic [3:0] LAT = 4'(RD_LAT);

   state_t     state;
   logic [3:0] count;
   logic       side_d;
   logic       data_hs;
   logic       inst_hs;
   logic       write_hs;
   logic       unused_bits;

   assign Mem_Req_Ready  = (state == IDLE);
   assign Inst_Req_Ready = (state == IDLE) & ~MemRead & ~MemWrite;

   assign data_hs  = Mem_Req_Ready & (MemRead | MemWrite);
   assign inst_hs  = Inst_Req_Ready & Inst_Req_Valid;
   assign write_hs = data_hs & MemWrite;

   // A combined read+write is a write; the read half is silently dropped.
   assign ram_en    = data_hs | inst_hs;
   assign ram_we    = write_hs ? Write_strb : 4'b0000;
   assign ram_wdata = write_hs ? Write_data : 32'h0;
   assign ram_addr  = data_hs ? Address[ADDR_W+1:2] :
                      inst_hs ? PC[ADDR_W+1:2] : '0;

   assign unused_bits = ^{Address[31:ADDR_W+2], Address[1:0], PC[31:ADDR_W+2], PC[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         count           <= 4'd0;
         side_d          <= 1'b0;
         Inst_Valid      <= 1'b0;
         Read_data_Valid <= 1'b0;
         Instruction     <= 32'h0;
         Read_data       <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (data_hs && !MemWrite) begin
                  state  <= WAIT;
                  count  <= LAT;
                  side_d <= 1'b1;
               end else if (inst_hs) begin
                  state  <= WAIT;
                  count  <= LAT;
                  side_d <= 1'b0;
               end
            end
            WAIT: begin
               // count reaches 1 in the cycle the SRAM presents the word
               if (count == 4'd1) begin
                  count <= 4'd0;
                  if (side_d) begin
                     Read_data       <= ram_rdata;
                     Read_data_Valid <= 1'b1;
                     state           <= RESP_D;
                  end else begin
                     Instruction <= ram_rdata;
                     Inst_Valid  <= 1'b1;
                     state       <= RESP_I;
                  end
               end else begin
                  count <= count - 4'd1;
               end
            end
            RESP_I: begin
               if (Inst_Ready) begin
                  Inst_Valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            RESP_D: begin
               if (Read_data_Ready) begin
                  Read_data_Valid <= 1'b0;
                  state           <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb/tb_cpu_mem_bridge.sv - directed vector bench for cpu_mem_bridge
// Instance a uses RD_LAT=1/ADDR_W=14; instance b uses RD_LAT=4/ADDR_W=10.
module tb_cpu_mem_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] PC = '0, Address = '0, Write_data = '0;
   logic [3:0]  Write_strb = '0;
   logic        Inst_Req_Valid = 0, Inst_Ready = 1, MemWrite = 0, MemRead = 0, Read_data_Ready = 1;
   logic        Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid, ram_en;
   logic [31:0] Instruction, Read_data, ram_wdata, ram_rdata;
   logic [3:0]  ram_we;
   logic [13:0] ram_addr;

   logic        b_mem_read = 0, b_read_data_ready = 1;
   logic [31:0] b_address = '0;
   logic        b_inst_req_ready, b_inst_valid, b_mem_req_ready, b_read_data_valid, b_ram_en;
   logic [31:0] b_instruction, b_read_data, b_ram_wdata, b_ram_rdata;
   logic [3:0]  b_ram_we;
   logic [9:0]  b_ram_addr;

   int applied = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cpu_mem_bridge #(.ADDR_W(14), .RD_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
      .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready), .Address(Address),
      .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb), .MemRead(MemRead),
      .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
      .Read_data_Ready(Read_data_Ready), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

   cpu_mem_bridge #(.ADDR_W(10), .RD_LAT(4)) dut_b (
      .clk(clk), .rst(rst), .PC(32'h0), .Inst_Req_Valid(1'b0), .Inst_Req_Ready(b_inst_req_ready),
      .Instruction(b_instruction), .Inst_Valid(b_inst_valid), .Inst_Ready(1'b1), .Address(b_address),
      .MemWrite(1'b0), .Write_data(32'h0), .Write_strb(4'h0), .MemRead(b_mem_read),
      .Mem_Req_Ready(b_mem_req_ready), .Read_data(b_read_data), .Read_data_Valid(b_read_data_valid),
      .Read_data_Ready(b_read_data_ready), .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
      .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata));

   // SRAM models: outside the read-valid window the data bus carries a poison word
   logic [31:0] mem_a [0:16383];
   logic [31:0] mem_b [0:1023];
   logic [31:0] pipe_a;
   logic [31:0] pipe_b [0:3];

   always @(posedge clk) begin
      pipe_a <= 32'hDEADBEEF;
      if (ram_en) begin
         if (ram_we == 4'b0000) pipe_a <= mem_a[ram_addr];
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem_a[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
   end
   assign ram_rdata = pipe_a;

   always @(posedge clk) begin
      pipe_b[0] <= (b_ram_en && b_ram_we == 4'b0000) ? mem_b[b_ram_addr] : 32'hDEADBEEF;
      for (int k = 1; k < 4; k++) pipe_b[k] <= pipe_b[k-1];
   end
   assign b_ram_rdata = pipe_b[3];

   typedef struct {
      logic        rd, wr, iv;
      logic [31:0] addr, pc, wdata;
      logic [3:0]  strb;
      logic        exp_en;
      logic [3:0]  exp_we;
      logic [13:0] exp_ram_addr;
      logic        exp_mrdy, exp_irdy;
      logic [1:0]  exp_resp;   // 0 none, 1 instruction, 2 data
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wait_valid(input string name);
      int k = 0;
      while (!(Inst_Valid || Read_data_Valid) && k < 20) begin
         @(negedge clk); #1;
         k++;
      end
      chk({name, "_timeout"}, 32'(k < 20), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem_a[i] = 32'h0;
      for (int i = 0; i < 1024; i++) mem_b[i] = 32'h0;
      mem_a[2] = 32'h12345678;
      mem_b[1] = 32'hCAFEF00D;

      vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hAABBCCDD, 4'b0101, 1'b1, 4'b0101, 14'h4, 1'b1, 1'b0, 2'd0, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 4'b0000, 1'b1, 4'b0000, 14'h4, 1'b1, 1'b0, 2'd2, 32'h00BB00DD};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h8, 32'h0, 4'b0000, 1'b1, 4'b0000, 14'h2, 1'b1, 1'b1, 2'd1, 32'h12345678};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 32'hFFFFFFFF, 4'b1111, 1'b1, 4'b1111, 14'h5, 1'b1, 1'b0, 2'd0, 32'h0};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 32'h0, 4'b0000, 1'b1, 4'b0000, 14'h5, 1'b1, 1'b0, 2'd2, 32'hFFFFFFFF};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h11223344, 4'b1010, 1'b1, 4'b1010, 14'h4, 1'b1, 1'b0, 2'd0, 32'h0};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h00010010, 32'h0, 4'b0000, 1'b1, 4'b0000, 14'h4, 1'b1, 1'b1, 2'd1, 32'h11BB33DD};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h20, 32'h8, 32'h00000055, 4'b0001, 1'b1, 4'b0001, 14'h8, 1'b1, 1'b0, 2'd0, 32'h0};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 4'b0000, 1'b1, 4'b0000, 14'h8, 1'b1, 1'b0, 2'd2, 32'h00000055};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_inst_valid", Inst_Valid, 0);
      chk("rst_rd_valid", Read_data_Valid, 0);
      chk("rst_instruction", Instruction, 0);
      chk("rst_read_data", Read_data, 0);
      chk("rst_mem_ready", Mem_Req_Ready, 1);
      chk("rst_inst_ready", Inst_Req_Ready, 1);

      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         MemRead = vecs[i].rd; MemWrite = vecs[i].wr; Inst_Req_Valid = vecs[i].iv;
         Address = vecs[i].addr; PC = vecs[i].pc; Write_data = vecs[i].wdata; Write_strb = vecs[i].strb;
         #1;
         chk($sformatf("v%0d_ram_en", i), ram_en, vecs[i].exp_en);
         chk($sformatf("v%0d_ram_we", i), ram_we, vecs[i].exp_we);
         chk($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].exp_ram_addr);
         chk($sformatf("v%0d_mem_ready", i), Mem_Req_Ready, vecs[i].exp_mrdy);
         chk($sformatf("v%0d_inst_ready", i), Inst_Req_Ready, vecs[i].exp_irdy);
         if (vecs[i].wr) chk($sformatf("v%0d_ram_wdata", i), ram_wdata, vecs[i].wdata);
         @(negedge clk);
         MemRead = 0; MemWrite = 0; Inst_Req_Valid = 0;
         #1;
         chk($sformatf("v%0d_ram_en_after", i), {ram_en, ram_we}, 0);
         if (vecs[i].exp_resp == 2'd0) begin
            chk($sformatf("v%0d_stay_idle", i), {Mem_Req_Ready, Inst_Valid, Read_data_Valid}, 3'b100);
         end else begin
            wait_valid($sformatf("v%0d", i));
            if (vecs[i].exp_resp == 2'd1) begin
               chk($sformatf("v%0d_valids", i), {Inst_Valid, Read_data_Valid}, 2'b10);
               chk($sformatf("v%0d_instruction", i), Instruction, vecs[i].exp_data);
            end else begin
               chk($sformatf("v%0d_valids", i), {Inst_Valid, Read_data_Valid}, 2'b01);
               chk($sformatf("v%0d_read_data", i), Read_data, vecs[i].exp_data);
            end
            @(negedge clk); #1;
            chk($sformatf("v%0d_valid_drop", i), {Inst_Valid, Read_data_Valid, Mem_Req_Ready}, 3'b001);
         end
      end

      // Fetch latency with Inst_Ready tied high: valid for exactly one cycle
      @(negedge clk);
      Inst_Req_Valid = 1; PC = 32'h8;
      @(negedge clk);
      Inst_Req_Valid = 0;
      #1;
      chk("lat_t1_valid", Inst_Valid, 0);
      chk("lat_t1_ram_en", ram_en, 0);
      @(negedge clk); #1;
      chk("lat_t2_valid", Inst_Valid, 1);
      chk("lat_t2_data", Instruction, 32'h12345678);
      @(negedge clk); #1;
      chk("lat_t3_valid", Inst_Valid, 0);
      chk("lat_t3_inst_ready", Inst_Req_Ready, 1);

      // Simultaneous requests with a stalled data response
      @(negedge clk);
      Read_data_Ready = 0;
      Inst_Req_Valid = 1; PC = 32'h8; MemRead = 1; Address = 32'h10;
      #1;
      chk("arb_inst_ready", Inst_Req_Ready, 0);
      chk("arb_ram_addr", ram_addr, 14'h4);
      @(negedge clk);
      MemRead = 0;
      #1;
      wait_valid("arb");
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d_state", c), {Read_data_Valid, Inst_Valid, Mem_Req_Ready, Inst_Req_Ready}, 4'b1000);
         chk($sformatf("stall%0d_data", c), Read_data, 32'h11BB33DD);
         @(negedge clk); #1;
      end
      Read_data_Ready = 1;
      @(negedge clk); #1;
      chk("arb_rd_drop", Read_data_Valid, 0);
      chk("arb_inst_now_ready", Inst_Req_Ready, 1);
      chk("arb_inst_addr", ram_addr, 14'h2);
      @(negedge clk);
      Inst_Req_Valid = 0;
      #1;
      wait_valid("arb_inst");
      chk("arb_instruction", Instruction, 32'h12345678);
      chk("arb_rd_held", Read_data, 32'h11BB33DD);
      @(negedge clk);

      // RD_LAT=4, ADDR_W=10: aliased address and capture timing
      @(negedge clk);
      b_mem_read = 1; b_address = 32'h1004;
      #1;
      chk("b_ram_addr", b_ram_addr, 10'h001);
      @(negedge clk);
      b_mem_read = 0;
      for (int k = 1; k <= 5; k++) begin
         #1;
         chk($sformatf("b_valid_k%0d", k), b_read_data_valid, (k == 5) ? 1 : 0);
         if (k < 5) @(negedge clk);
      end
      chk("b_read_data", b_read_data, 32'hCAFEF00D);
      @(negedge clk);

      // Asynchronous reset mid-WAIT discards the pending read
      @(negedge clk);
      MemRead = 1; Address = 32'h10;
      @(negedge clk);
      MemRead = 0;
      #2 rst = 1;
      #1;
      chk("rstw_mem_ready", Mem_Req_Ready, 1);
      chk("rstw_valids", {Read_data_Valid, Inst_Valid}, 0);
      chk("rstw_read_data", Read_data, 0);
      @(negedge clk);
      rst = 0;
      begin
         logic seen = 0;
         repeat (4) begin
            @(negedge clk); #1;
            seen |= Read_data_Valid;
         end
         chk("rstw_no_resp", seen, 0);
      end

      // Asynchronous reset while a response is being held
      @(negedge clk);
      Read_data_Ready = 0; MemRead = 1; Address = 32'h14;
      @(negedge clk);
      MemRead = 0;
      #1;
      wait_valid("rstr");
      #2 rst = 1;
      #1;
      chk("rstr_valid_drop", Read_data_Valid, 0);
      chk("rstr_mem_ready", Mem_Req_Ready, 1);
      @(negedge clk);
      rst = 0;
      Read_data_Ready = 1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
